// File: rtl/nn_index_divider.sv
`default_nettype none
// ============================================================================
// Module   : nn_index_divider
// Purpose  : round(shifted_index / shift) using a restoring divider, saturated to OUT_W bits.
// Revision : 1.0
// ============================================================================
module nn_index_divider #(
    parameter int FRAC_BITS = 20,
    parameter int SHIFT_W   = 32,
    parameter int OUT_W     = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [10:0]        shifted_index,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   source_index,
    output logic               ovr
);

    localparam int IDX_W = 11;
    localparam int DVD_W = IDX_W + FRAC_BITS + 1;
    localparam int CNT_W = $clog2(DVD_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               chk_q, chk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;
    logic [DVD_W-1:0]   rem_q, rem_d;
    logic [DVD_W-2:0]   quo_q, quo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic [OUT_W-1:0]   idx_q, idx_d;

    logic [DVD_W:0]     div_ext;
    logic [DVD_W:0]     rem_shift;
    logic [DVD_W:0]     rem_sub;
    logic [DVD_W:0]     rnd;
    logic [DVD_W-1:0]   quo_next;
    logic               q_bit;
    logic               div_bad;

    always_comb begin
        div_ext   = {{(DVD_W + 2 - SHIFT_W){1'b0}}, shift_q[SHIFT_W-2:0]};
        div_bad   = (shift_q == '0) || shift_q[SHIFT_W-1];
        rem_shift = {rem_q, dvd_q[DVD_W-1]};
        q_bit     = (rem_shift >= div_ext);
        rem_sub   = rem_shift - div_ext;
        quo_next  = {quo_q, q_bit};
        // q carries one extra fractional bit, so (q + 1) >> 1 rounds half up
        rnd       = ({1'b0, quo_next} + {{DVD_W{1'b0}}, 1'b1}) >> 1;

        state_d = state_q;
        chk_d   = chk_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = shift;
                    dvd_d   = {shifted_index, {(FRAC_BITS + 1){1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    chk_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (chk_q) begin
                    // first CALC cycle only validates the latched divisor
                    chk_d = 1'b0;
                    cnt_d = '0;
                    if (div_bad) begin
                        idx_d   = '1;
                        ovr_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    rem_d = q_bit ? rem_sub[DVD_W-1:0] : rem_shift[DVD_W-1:0];
                    quo_d = quo_next[DVD_W-2:0];
                    dvd_d = dvd_q << 1;
                    cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_CNT) begin
                        if (|rnd[DVD_W:OUT_W]) begin
                            idx_d = '1;
                            ovr_d = 1'b1;
                        end else begin
                            idx_d = rnd[OUT_W-1:0];
                            ovr_d = 1'b0;
                        end
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            chk_q   <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            idx_q   <= idx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign source_index = idx_q;
    assign ovr          = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_index_divider.sv
`default_nettype none
// Randomized and directed checks of nn_index_divider against an arithmetic reference.
module tb_nn_index_divider;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] shift = '0;
    logic [10:0] shifted_index = '0;
    logic        busy;
    logic        done;
    logic [8:0]  source_index;
    logic        ovr;

    int n_vec = 0;
    int n_err = 0;

    nn_index_divider dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .shift        (shift),
        .shifted_index(shifted_index),
        .busy         (busy),
        .done         (done),
        .source_index (source_index),
        .ovr          (ovr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: {ovr, source_index} from plain integer arithmetic.
    function automatic logic [9:0] ref_div(input logic [31:0] s, input logic [10:0] ix);
        longint unsigned num, q, r;
        if (s == 32'd0 || s[31]) return {1'b1, 9'd511};
        num = longint'(ix) * 64'd2097152;
        q   = num / longint'(s);
        r   = (q + 64'd1) / 64'd2;
        if (r > 64'd511) return {1'b1, 9'd511};
        return {1'b0, r[8:0]};
    endfunction

    task automatic run_op(input logic [31:0] s, input logic [10:0] ix, input bit poke);
        logic [9:0] exp;
        int cyc;
        int exp_lat;
        exp     = ref_div(s, ix);
        exp_lat = (s == 32'd0 || s[31]) ? 2 : 34;
        @(negedge clk);
        shift = s; shifted_index = ix; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        shift = $urandom; shifted_index = 11'($urandom);
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!done && cyc < 60) begin
            start = (poke && cyc == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_val("latency", cyc, exp_lat);
        check_val("source_index", {23'd0, source_index}, {23'd0, exp[8:0]});
        check_val("ovr", {31'd0, ovr}, {31'd0, exp[9]});
        check_val("busy_in_done", {31'd0, busy}, 32'd1);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        check_val("idle_after_done", {31'd0, busy}, 32'd0);
        check_val("hold_index", {22'd0, ovr, source_index}, {22'd0, exp});
    endtask

    initial begin
        int dones;
        logic [31:0] s;

        // Reset with start toggling
        reset_n = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
            shift = 32'h0020_0000;
            if (done) dones++;
        end
        start = 1'b0;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done_pulses", dones, 0);
        check_val("rst_index", {23'd0, source_index}, 32'd0);
        check_val("rst_ovr", {31'd0, ovr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases
        run_op(32'h0020_0000, 11'd100, 1'b0);
        run_op(32'h0018_0000, 11'd100, 1'b1);
        run_op(32'h0018_0000, 11'd1,   1'b0);
        run_op(32'h0008_0000, 11'd200, 1'b1);
        run_op(32'h0008_0000, 11'd300, 1'b0);
        run_op(32'h0000_0000, 11'd77,  1'b1);
        run_op(32'h8010_0000, 11'd5,   1'b1);
        run_op(32'h0000_0001, 11'd0,   1'b0);
        run_op(32'h7FFF_FFFF, 11'd2047, 1'b0);

        // Reset in the middle of a calculation
        @(negedge clk);
        shift = 32'h0020_0000; shifted_index = 11'd500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        check_val("midrst_index", {22'd0, ovr, source_index}, 32'd0);
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_val("midrst_no_done", dones, 0);
        run_op(32'h0010_0000, 11'd511, 1'b0);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       s = 32'd0;
                1:       s = 32'h8000_0000 | $urandom;
                2:       s = $urandom_range(1, 32'h0000_FFFF);
                default: s = $urandom_range(32'h0004_0000, 32'h0100_0000);
            endcase
            run_op(s, 11'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
